// File: rtl/led_centroid_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_centroid_reader_pkg
// Purpose : Shared constants for the calibration read-back path: reader FSM
//           state encoding and the LED-ID value that marks a disabled pixel.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package led_centroid_reader_pkg;

  typedef logic [2:0] reader_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;

  // Accum RAM ID word width used across the calibration path.
  localparam int LED_ID_WIDTH_DEFAULT = 10;

  // All-ones ID written for pixels that belong to no LED.
  localparam logic [LED_ID_WIDTH_DEFAULT-1:0] LED_ID_INVALID = '1;

endpackage
`default_nettype wire

// File: rtl/led_centroid_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : led_centroid_reader_if
// Purpose : Bundles the accum RAM READ request/response channel and the
//           per-LED record stream of the centroid reader.
// Ports   : master = reader side (drives ram_addr/ram_req_valid and rec_*),
//           slave  = RAM + downstream mapping side.
// Rev     : 1.0  initial release
// ============================================================================
interface led_centroid_reader_if #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  parameter int GRID_W            = 80,
  parameter int GRID_H            = 45
);
  localparam int DEPTH = GRID_W * GRID_H;
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int A_W   = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SX_W  = X_W + CNT_W;
  localparam int SY_W  = Y_W + CNT_W;
  localparam int LED_W = $clog2(NUM_LEDS);

  logic [A_W-1:0]               ram_addr;
  logic                         ram_req_valid;
  logic                         ram_rsp_valid;
  logic [LED_ADDRESS_WIDTH-1:0] ram_rsp_id;
  logic                         rec_valid;
  logic                         rec_ready;
  logic [LED_W-1:0]             rec_led;
  logic [SX_W-1:0]              rec_sum_x;
  logic [SY_W-1:0]              rec_sum_y;
  logic [CNT_W-1:0]             rec_count;

  modport master (
    output ram_addr, ram_req_valid,
    input  ram_rsp_valid, ram_rsp_id,
    output rec_valid, rec_led, rec_sum_x, rec_sum_y, rec_count,
    input  rec_ready
  );

  modport slave (
    input  ram_addr, ram_req_valid,
    output ram_rsp_valid, ram_rsp_id,
    input  rec_valid, rec_led, rec_sum_x, rec_sum_y, rec_count,
    output rec_ready
  );

endinterface
`default_nettype wire

// File: rtl/led_centroid_reader_led_stat_bank.sv
`default_nettype none
// ============================================================================
// Module  : led_stat_bank
// Purpose : Per-LED statistics store {sum_x, sum_y, count}. One write port,
//           one synchronous read port, plus a two-stage read-modify-write
//           pipe that accumulates one pixel per cycle with forwarding.
// Ports   : clr_en/clr_addr      zero one entry
//           upd_valid/id/x/y     accumulate pixel (x,y) into entry id
//           rd_en/rd_addr        plain read (used while no update is active)
//           rd_data              registered read result
//           pipe_busy            an accumulate is still pending its write
// Rev     : 1.0  initial release
// ============================================================================
module led_stat_bank #(
  parameter int NUM_LEDS = 50,
  parameter int LED_W    = 6,
  parameter int X_W      = 7,
  parameter int Y_W      = 6,
  parameter int CNT_W    = 12,
  parameter int SX_W     = 19,
  parameter int SY_W     = 18
) (
  input  wire logic                            clk_pixel,
  input  wire logic                            rst_n,
  input  wire logic                            clr_en,
  input  wire logic [LED_W-1:0]                clr_addr,
  input  wire logic                            upd_valid,
  input  wire logic [LED_W-1:0]                upd_id,
  input  wire logic [X_W-1:0]                  upd_x,
  input  wire logic [Y_W-1:0]                  upd_y,
  input  wire logic                            rd_en,
  input  wire logic [LED_W-1:0]                rd_addr,
  output logic      [SX_W+SY_W+CNT_W-1:0]      rd_data,
  output logic                                 pipe_busy
);
  localparam int REC_W = SX_W + SY_W + CNT_W;

  logic [REC_W-1:0] r_mem [0:NUM_LEDS-1];
  logic [REC_W-1:0] r_rd_q;

  logic             r_s2_valid;
  logic [LED_W-1:0] r_s2_id;
  logic [X_W-1:0]   r_s2_x;
  logic [Y_W-1:0]   r_s2_y;
  logic             r_s2_fwd;
  logic [REC_W-1:0] r_fwd_data;

  logic             w_rd_en;
  logic [LED_W-1:0] w_rd_addr;
  logic [REC_W-1:0] w_base;
  logic [SX_W-1:0]  w_base_sx;
  logic [SY_W-1:0]  w_base_sy;
  logic [CNT_W-1:0] w_base_cnt;
  logic [REC_W-1:0] w_new;

  // An accumulate always owns the read port; plain reads only happen in EMIT.
  assign w_rd_en   = upd_valid || rd_en;
  assign w_rd_addr = upd_valid ? upd_id : rd_addr;

  // The memory read for an id issued one cycle after the same id was read
  // misses the pending write, so that case takes the stage-2 result instead.
  assign w_base = r_s2_fwd ? r_fwd_data : r_rd_q;
  assign {w_base_sx, w_base_sy, w_base_cnt} = w_base;
  assign w_new = {w_base_sx + SX_W'(r_s2_x),
                  w_base_sy + SY_W'(r_s2_y),
                  w_base_cnt + CNT_W'(1)};

  assign rd_data   = r_rd_q;
  assign pipe_busy = r_s2_valid;

  always_ff @(posedge clk_pixel) begin
    if (clr_en) begin
      r_mem[clr_addr] <= '0;
    end else if (r_s2_valid) begin
      r_mem[r_s2_id] <= w_new;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
      r_s2_fwd   <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      if (w_rd_en) begin
        r_rd_q <= r_mem[w_rd_addr];
      end
      r_s2_valid <= upd_valid;
      if (upd_valid) begin
        r_s2_id    <= upd_id;
        r_s2_x     <= upd_x;
        r_s2_y     <= upd_y;
        r_s2_fwd   <= r_s2_valid && (r_s2_id == upd_id);
        r_fwd_data <= w_new;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_centroid_reader.sv
`default_nettype none
// ============================================================================
// Module  : led_centroid_reader
// Purpose : Sweeps every downsampled pixel of the accum RAM with READ
//           requests, accumulates per-LED sum_x/sum_y/count and streams one
//           record per LED. Sequence: IDLE -> CLEAR -> SCAN -> DRAIN -> EMIT.
// Ports   : clk_pixel, rst_n (async, active low)
//           start  rising edge starts a sweep from IDLE
//           busy   high outside IDLE
//           done   pulse on the final record handshake
//           bus    RAM request/response and record stream (master side)
// Rev     : 1.0  initial release
// ============================================================================
module led_centroid_reader
  import led_centroid_reader_pkg::*;
#(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  parameter int GRID_W            = 80,
  parameter int GRID_H            = 45
) (
  input  wire logic             clk_pixel,
  input  wire logic             rst_n,
  input  wire logic             start,
  output logic                  busy,
  output logic                  done,
  led_centroid_reader_if.master bus
);
  localparam int DEPTH = GRID_W * GRID_H;
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int A_W   = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SX_W  = X_W + CNT_W;
  localparam int SY_W  = Y_W + CNT_W;
  localparam int LED_W = $clog2(NUM_LEDS);
  localparam int REC_W = SX_W + SY_W + CNT_W;

  localparam logic [A_W-1:0]               c_last_addr   = A_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]             c_depth_cnt   = CNT_W'(DEPTH);
  localparam logic [LED_W-1:0]             c_last_led    = LED_W'(NUM_LEDS - 1);
  localparam logic [X_W-1:0]               c_last_x      = X_W'(GRID_W - 1);
  localparam logic [LED_ADDRESS_WIDTH-1:0] c_num_leds_id = LED_ADDRESS_WIDTH'(NUM_LEDS);

  reader_state_t    r_state;
  logic             r_start_q;
  logic [LED_W-1:0] r_clr_idx;
  logic [LED_W-1:0] r_emit_idx;
  logic             r_emit_issue;
  logic             r_rec_valid;
  logic [A_W-1:0]   r_req_addr;
  logic [CNT_W-1:0] r_rsp_cnt;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;

  logic             w_sweep_start;
  logic             w_rsp_accept;
  logic             w_upd_valid;
  logic             w_handshake;
  logic             w_last_rec;
  logic             w_pipe_busy;
  logic [REC_W-1:0] w_rd_data;

  assign w_sweep_start = (r_state == ST_IDLE) && start && !r_start_q;

  // Responses are counted only while a sweep is collecting and only up to
  // DEPTH, so stray responses cannot disturb the x/y raster.
  assign w_rsp_accept = bus.ram_rsp_valid &&
                        ((r_state == ST_SCAN) || (r_state == ST_DRAIN)) &&
                        (r_rsp_cnt != c_depth_cnt);
  assign w_upd_valid  = w_rsp_accept && (bus.ram_rsp_id < c_num_leds_id);

  assign w_handshake  = (r_state == ST_EMIT) && r_rec_valid && bus.rec_ready;
  assign w_last_rec   = (r_emit_idx == c_last_led);

  assign busy              = (r_state != ST_IDLE);
  assign done              = w_handshake && w_last_rec;
  assign bus.ram_req_valid = (r_state == ST_SCAN);
  assign bus.ram_addr      = r_req_addr;
  assign bus.rec_valid     = r_rec_valid;
  assign bus.rec_led       = r_emit_idx;
  assign {bus.rec_sum_x, bus.rec_sum_y, bus.rec_count} = w_rd_data;

  led_stat_bank #(
    .NUM_LEDS (NUM_LEDS),
    .LED_W    (LED_W),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .CNT_W    (CNT_W),
    .SX_W     (SX_W),
    .SY_W     (SY_W)
  ) u_stat_bank (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .clr_en    (r_state == ST_CLEAR),
    .clr_addr  (r_clr_idx),
    .upd_valid (w_upd_valid),
    .upd_id    (bus.ram_rsp_id[LED_W-1:0]),
    .upd_x     (r_x),
    .upd_y     (r_y),
    .rd_en     ((r_state == ST_EMIT) && r_emit_issue),
    .rd_addr   (r_emit_idx),
    .rd_data   (w_rd_data),
    .pipe_busy (w_pipe_busy)
  );

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_start_q    <= 1'b0;
      r_clr_idx    <= '0;
      r_emit_idx   <= '0;
      r_emit_issue <= 1'b0;
      r_rec_valid  <= 1'b0;
      r_req_addr   <= '0;
    end else begin
      r_start_q <= start;
      case (r_state)
        ST_IDLE: begin
          if (w_sweep_start) begin
            r_state    <= ST_CLEAR;
            r_clr_idx  <= '0;
            r_req_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == c_last_led) begin
            r_state <= ST_SCAN;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_req_addr == c_last_addr) begin
            r_state    <= ST_DRAIN;
            r_req_addr <= '0;
          end else begin
            r_req_addr <= r_req_addr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if ((r_rsp_cnt == c_depth_cnt) && !w_pipe_busy) begin
            r_state      <= ST_EMIT;
            r_emit_idx   <= '0;
            r_emit_issue <= 1'b1;
          end
        end
        ST_EMIT: begin
          // Read issue cycle, then hold the record until it is taken.
          if (r_emit_issue) begin
            r_emit_issue <= 1'b0;
            r_rec_valid  <= 1'b1;
          end else if (w_handshake) begin
            r_rec_valid <= 1'b0;
            if (w_last_rec) begin
              r_state <= ST_IDLE;
            end else begin
              r_emit_idx   <= r_emit_idx + 1'b1;
              r_emit_issue <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response-side raster position, independent of the request address.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_cnt <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else if (w_sweep_start) begin
      r_rsp_cnt <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else if (w_rsp_accept) begin
      r_rsp_cnt <= r_rsp_cnt + 1'b1;
      if (r_x == c_last_x) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
